// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port SRAM between two valid/ready requesters
// with round-robin arbitration, 1-cycle read latency and an optional post-reset zero scrub.
`default_nettype none

module sram_port_arbiter #(
  parameter int          ADDR_W   = 12,
  parameter bit          SCRUB_EN = 1'b1,
  parameter logic [2:0]  EMA_VAL  = 3'b000
) (
  input  logic              top_clk,
  input  logic              top_reset,
  // requester 0
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic              r0_write,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [31:0]       r0_wdata,
  input  logic [3:0]        r0_be,
  output logic              r0_rvalid,
  output logic [31:0]       r0_rdata,
  // requester 1
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic              r1_write,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [31:0]       r1_wdata,
  input  logic [3:0]        r1_be,
  output logic              r1_rvalid,
  output logic [31:0]       r1_rdata,
  output logic              scrub_done,
  // SRAM macro
  output logic              CLK,
  output logic              CEN,
  output logic              GWEN,
  output logic [3:0]        WEN,
  output logic [ADDR_W-1:0] A,
  output logic [31:0]       D,
  output logic              RETN,
  output logic [2:0]        EMA,
  input  logic [31:0]       Q
);

  typedef enum logic [0:0] {
    SCRUB = 1'b0,
    RUN   = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   scrub_addr_q, scrub_addr_d;
  logic                scrub_done_q, scrub_done_d;
  logic                last_grant_q, last_grant_d;
  logic                r0_rvalid_q, r0_rvalid_d;
  logic                r1_rvalid_q, r1_rvalid_d;
  logic                grant;
  logic                accept;

  always_ff @(posedge top_clk) begin
    if (top_reset) begin
      state_q      <= SCRUB_EN ? SCRUB : RUN;
      scrub_addr_q <= '0;
      scrub_done_q <= 1'b0;
      last_grant_q <= 1'b1;
      r0_rvalid_q  <= 1'b0;
      r1_rvalid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      scrub_addr_q <= scrub_addr_d;
      scrub_done_q <= scrub_done_d;
      last_grant_q <= last_grant_d;
      r0_rvalid_q  <= r0_rvalid_d;
      r1_rvalid_q  <= r1_rvalid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    scrub_addr_d = scrub_addr_q;
    scrub_done_d = scrub_done_q;
    last_grant_d = last_grant_q;
    r0_rvalid_d  = 1'b0;
    r1_rvalid_d  = 1'b0;
    r0_ready     = 1'b0;
    r1_ready     = 1'b0;
    accept       = 1'b0;
    CEN          = 1'b1;
    GWEN         = 1'b1;
    WEN          = 4'hF;
    A            = '0;
    D            = '0;

    // Contention alternates away from the last winner; a lone requester always wins.
    if (r0_valid && r1_valid) grant = ~last_grant_q;
    else if (r0_valid)        grant = 1'b0;
    else                      grant = 1'b1;

    unique case (state_q)
      SCRUB: begin
        CEN          = 1'b0;
        GWEN         = 1'b0;
        WEN          = 4'h0;
        A            = scrub_addr_q;
        scrub_addr_d = scrub_addr_q + 1'b1;
        if (&scrub_addr_q) begin
          state_d      = RUN;
          scrub_done_d = 1'b1;
        end
      end
      RUN: begin
        scrub_done_d = 1'b1;
        accept       = grant ? r1_valid : r0_valid;
        r0_ready     = accept & ~grant;
        r1_ready     = accept & grant;
        if (accept) begin
          last_grant_d = grant;
          CEN          = 1'b0;
          A            = grant ? r1_addr : r0_addr;
          if (grant ? r1_write : r0_write) begin
            GWEN = 1'b0;
            WEN  = grant ? ~r1_be : ~r0_be;
            D    = grant ? r1_wdata : r0_wdata;
          end else begin
            r0_rvalid_d = ~grant;
            r1_rvalid_d = grant;
          end
        end
      end
      default: ;
    endcase

    // Reset overrides everything combinationally so no access or handshake leaks through.
    if (top_reset) begin
      r0_ready = 1'b0;
      r1_ready = 1'b0;
      CEN      = 1'b1;
      GWEN     = 1'b1;
      WEN      = 4'hF;
      A        = '0;
      D        = '0;
    end
  end

  assign r0_rvalid  = r0_rvalid_q & ~top_reset;
  assign r1_rvalid  = r1_rvalid_q & ~top_reset;
  assign r0_rdata   = r0_rvalid ? Q : 32'h0;
  assign r1_rdata   = r1_rvalid ? Q : 32'h0;
  assign scrub_done = scrub_done_q;
  assign CLK        = top_clk;
  assign RETN       = ~top_reset;
  assign EMA        = EMA_VAL;

endmodule

`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed bench for sram_port_arbiter with a behavioural
// registered-output SRAM model that is refilled with a nonzero pattern on every reset.
`default_nettype none

module tb_sram_port_arbiter;

  localparam int AW = 12;

  logic          top_clk = 1'b0;
  logic          top_reset;
  logic          r0_valid, r0_ready, r0_write, r0_rvalid;
  logic [AW-1:0] r0_addr;
  logic [31:0]   r0_wdata, r0_rdata;
  logic [3:0]    r0_be;
  logic          r1_valid, r1_ready, r1_write, r1_rvalid;
  logic [AW-1:0] r1_addr;
  logic [31:0]   r1_wdata, r1_rdata;
  logic [3:0]    r1_be;
  logic          scrub_done;
  logic          CLK, CEN, GWEN, RETN;
  logic [3:0]    WEN;
  logic [AW-1:0] A;
  logic [31:0]   D, Q;
  logic [2:0]    EMA;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 top_clk = ~top_clk;

  sram_port_arbiter #(.ADDR_W(AW), .SCRUB_EN(1'b1), .EMA_VAL(3'b000)) dut (
    .top_clk(top_clk), .top_reset(top_reset),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_write(r0_write), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_be(r0_be), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_write(r1_write), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_be(r1_be), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .scrub_done(scrub_done),
    .CLK(CLK), .CEN(CEN), .GWEN(GWEN), .WEN(WEN), .A(A), .D(D),
    .RETN(RETN), .EMA(EMA), .Q(Q)
  );

  // SRAM model: registered Q on reads, per-byte active-low write enables.
  logic [31:0] mem [0:(1<<AW)-1];
  always @(posedge top_clk) begin
    if (top_reset) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= 32'hA5A5_A5A5;
    end else if (!CEN) begin
      if (!GWEN) begin
        for (int b = 0; b < 4; b++)
          if (!WEN[b]) mem[A][8*b +: 8] <= D[8*b +: 8];
      end else begin
        Q <= mem[A];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    r0_valid = 1'b0; r0_write = 1'b0; r0_addr = '0; r0_wdata = '0; r0_be = '0;
    r1_valid = 1'b0; r1_write = 1'b0; r1_addr = '0; r1_wdata = '0; r1_be = '0;
  endtask

  task automatic set_req(input int g, input logic wr, input logic [AW-1:0] a,
                         input logic [31:0] wd, input logic [3:0] be);
    if (g == 0) begin
      r0_valid = 1'b1; r0_write = wr; r0_addr = a; r0_wdata = wd; r0_be = be;
    end else begin
      r1_valid = 1'b1; r1_write = wr; r1_addr = a; r1_wdata = wd; r1_be = be;
    end
  endtask

  // Issues a write at the next falling edge; the following operation replaces it.
  task automatic do_write(input int g, input logic [AW-1:0] a, input logic [31:0] wd,
                          input logic [3:0] be, input string tag);
    @(negedge top_clk);
    idle();
    set_req(g, 1'b1, a, wd, be);
    #1;
    chk({tag, "_ready"}, (g == 0) ? r0_ready : r1_ready, 1);
  endtask

  task automatic do_read(input int g, input logic [AW-1:0] a, input logic [31:0] exp,
                         input string tag);
    @(negedge top_clk);
    idle();
    set_req(g, 1'b0, a, '0, '0);
    #1;
    chk({tag, "_ready"}, (g == 0) ? r0_ready : r1_ready, 1);
    @(negedge top_clk);
    idle();
    #1;
    chk({tag, "_rvalid"}, (g == 0) ? r0_rvalid : r1_rvalid, 1);
    chk({tag, "_rdata"},  (g == 0) ? r0_rdata  : r1_rdata,  exp);
    chk({tag, "_other_rvalid"}, (g == 0) ? r1_rvalid : r0_rvalid, 0);
  endtask

  // Holds both requesters valid through the scrub; counts cycles until scrub_done.
  task automatic wait_scrub(output int cnt, output int bad);
    cnt = 0;
    bad = 0;
    set_req(0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0);
    for (int i = 0; i < 5000; i++) begin
      @(negedge top_clk);
      #1;
      cnt++;
      if (scrub_done) break;
      if (r0_ready || r1_ready) bad++;
    end
    idle();
  endtask

  int cnt, bad;
  logic [AW-1:0] seq_addr [0:6];

  initial begin
    idle();
    top_reset = 1'b1;
    repeat (3) @(negedge top_clk);
    set_req(0, 1'b0, '0, '0, '0);
    #1;
    chk("rst_r0_ready", r0_ready, 0);
    chk("rst_r0_rvalid", r0_rvalid, 0);
    chk("rst_r1_rvalid", r1_rvalid, 0);
    chk("rst_scrub_done", scrub_done, 0);
    chk("rst_CEN", CEN, 1);
    chk("rst_GWEN", GWEN, 1);
    chk("rst_WEN", WEN, 4'hF);
    chk("rst_RETN", RETN, 0);
    chk("rst_EMA", EMA, 3'b000);
    chk("rst_CLK", CLK, top_clk);
    idle();

    // Scrub: first cycle after release writes zero to address 0.
    @(negedge top_clk);
    top_reset = 1'b0;
    #1;
    chk("scrub_RETN", RETN, 1);
    chk("scrub_CEN", CEN, 0);
    chk("scrub_GWEN", GWEN, 0);
    chk("scrub_WEN", WEN, 4'h0);
    chk("scrub_A0", A, 0);
    chk("scrub_D", D, 0);
    wait_scrub(cnt, bad);
    chk("scrub_cycles", cnt, 4096);
    chk("scrub_no_ready", bad, 0);
    do_read(0, 12'h000, 32'h0, "t1_rd000");
    do_read(0, 12'hFFF, 32'h0, "t1_rdFFF");

    // Single write then read-after-write on consecutive cycles.
    do_write(0, 12'h123, 32'hDEADBEEF, 4'hF, "t2_wr");
    chk("t2_CEN", CEN, 0);
    chk("t2_GWEN", GWEN, 0);
    chk("t2_WEN", WEN, 4'h0);
    chk("t2_A", A, 12'h123);
    chk("t2_D", D, 32'hDEADBEEF);
    do_read(0, 12'h123, 32'hDEADBEEF, "t2_rd");
    @(negedge top_clk);
    #1;
    chk("t2_rvalid_drop", r0_rvalid, 0);
    chk("t2_rdata_zero", r0_rdata, 0);

    // Byte enables, including an all-zero mask.
    do_write(0, 12'h010, 32'hFFFFFFFF, 4'hF, "t3_wr_full");
    do_write(0, 12'h010, 32'h00000000, 4'b0101, "t3_wr_part");
    chk("t3_WEN_part", WEN, 4'b1010);
    do_write(0, 12'h010, 32'h12345678, 4'b0000, "t3_wr_none");
    chk("t3_CEN_none", CEN, 0);
    chk("t3_WEN_none", WEN, 4'hF);
    do_read(0, 12'h010, 32'hFF00FF00, "t3_rd");

    // Preload 1..4 from r1, then four back-to-back r1 reads.
    for (int i = 1; i <= 4; i++) do_write(1, AW'(i), 32'(i), 4'hF, "t6_wr");
    for (int k = 0; k <= 4; k++) begin
      @(negedge top_clk);
      idle();
      if (k < 4) set_req(1, 1'b0, AW'(k + 1), '0, '0);
      #1;
      if (k < 4) chk("t6_r1_ready", r1_ready, 1);
      if (k > 0) begin
        chk("t6_r1_rvalid", r1_rvalid, 1);
        chk("t6_r1_rdata", r1_rdata, 32'(k));
        chk("t6_r0_rvalid", r0_rvalid, 0);
      end
    end

    // Contention: last winner was r1, so grants run 0,1,0,1,0,1.
    seq_addr[0] = 12'h001; seq_addr[1] = 12'h002; seq_addr[2] = 12'h003;
    seq_addr[3] = 12'h004; seq_addr[4] = 12'h001; seq_addr[5] = 12'h002;
    seq_addr[6] = 12'h003;
    for (int k = 0; k <= 6; k++) begin
      @(negedge top_clk);
      idle();
      if (k < 6) begin
        set_req(0, 1'b0, (k % 2 == 0) ? seq_addr[k] : seq_addr[k + 1], '0, '0);
        set_req(1, 1'b0, (k % 2 == 1) ? seq_addr[k] : seq_addr[k + 1], '0, '0);
      end
      #1;
      if (k < 6) begin
        chk("t4_r0_ready", r0_ready, (k % 2 == 0) ? 1 : 0);
        chk("t4_r1_ready", r1_ready, (k % 2 == 1) ? 1 : 0);
      end
      if (k > 0) begin
        chk("t4_r0_rvalid", r0_rvalid, ((k - 1) % 2 == 0) ? 1 : 0);
        chk("t4_r1_rvalid", r1_rvalid, ((k - 1) % 2 == 1) ? 1 : 0);
        chk("t4_rdata", ((k - 1) % 2 == 0) ? r0_rdata : r1_rdata, 32'(seq_addr[k - 1]));
      end
    end

    // Reset during the response cycle suppresses rvalid.
    @(negedge top_clk);
    idle();
    set_req(0, 1'b0, 12'h001, '0, '0);
    #1;
    chk("rstrd_ready", r0_ready, 1);
    @(negedge top_clk);
    idle();
    top_reset = 1'b1;
    #1;
    chk("rstrd_rvalid", r0_rvalid, 0);
    chk("rstrd_rdata", r0_rdata, 0);

    // Reset at scrub address 0x800 restarts the scrub from 0.
    @(negedge top_clk);
    top_reset = 1'b0;
    repeat (2048) @(negedge top_clk);
    #1;
    chk("t5_A_mid", A, 12'h800);
    chk("t5_CEN_mid", CEN, 0);
    top_reset = 1'b1;
    #1;
    chk("t5_CEN_in_reset", CEN, 1);
    repeat (2) @(negedge top_clk);
    top_reset = 1'b0;
    #1;
    chk("t5_A_restart", A, 0);
    chk("t5_done_low", scrub_done, 0);
    wait_scrub(cnt, bad);
    chk("t5_scrub_cycles", cnt, 4096);
    chk("t5_no_ready", bad, 0);
    do_read(1, 12'h7FF, 32'h0, "t5_rd7FF");
    do_read(0, 12'hFFF, 32'h0, "t5_rdFFF");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
